// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run/stop clock divider.
// The FSM encoding and the standard half-period presets live here.
package clk_div_pkg;

    localparam int DEF_CNT_W = 19;

    // Half-period minus one, counted in 50 MHz cycles.
    localparam int          DEF_HALF_100HZ = 249999;
    localparam logic [24:0] DEF_HALF_1HZ   = 25'd24999999;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    function automatic logic is_busy(input state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake between the register block (master) and the
// divider controller (slave): half-period offer, ready, and error pulse.
interface clk_div_ctrl_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_core.sv
// Half-period counter with registered toggle output and rising-edge tick.
// restart forces the idle condition; fall flags the wrap that ends a period.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_MHz,
    input  logic             reset_n,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             clk_out,
    output logic             tick,
    output logic             fall
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    // half only changes while cnt is 0, so equality is a safe terminal test.
    assign wrap = en && (cnt == half);
    assign fall = wrap && clk_out;

    // NOTE: every sequential update uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk_MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= wrap && !clk_out;
            if (wrap) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop controller for the programmable divider: start/stop FSM plus a
// one-deep pending half-period that only takes effect at a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_HALF = DEF_HALF_100HZ,
    parameter int MIN_HALF = 1
) (
    input  logic           clk_MHz,
    input  logic           reset_n,
    input  logic           start,
    input  logic           stop,
    clk_div_ctrl_if.slave  cfg,
    output logic           clk_out,
    output logic           tick,
    output logic           busy
);

    localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] MIN_HALF_W = CNT_W'(MIN_HALF);

    state_e           state, state_next;
    logic [CNT_W-1:0] active_half, active_next;
    logic [CNT_W-1:0] pending, pending_next;
    logic             pending_vld, pending_vld_next;
    logic             cfg_ready_q, cfg_err_q;
    logic             xfer, legal;
    logic             core_fall, core_restart;

    assign xfer          = cfg.cfg_valid && cfg_ready_q;
    assign legal         = cfg.cfg_half >= MIN_HALF_W;
    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;

    // NOTE: each always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (start && !stop) state_next = RUN;
            RUN:      if (stop) state_next = (!clk_out || core_fall) ? IDLE : STOPPING;
            STOPPING: if (core_fall) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign core_restart = (state_next == IDLE);

    // A pending value lands on the 1->0 wrap, or whenever a run ends.
    always_comb begin
        active_next      = active_half;
        pending_next     = pending;
        pending_vld_next = pending_vld;
        if (is_busy(state) && pending_vld && (core_fall || state_next == IDLE)) begin
            active_next      = pending;
            pending_vld_next = 1'b0;
        end
        if (xfer && legal) begin
            if (state == IDLE || state_next == IDLE) begin
                active_next = cfg.cfg_half;
            end else begin
                pending_next     = cfg.cfg_half;
                pending_vld_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_MHz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            active_half <= DEF_HALF_W;
            pending     <= '0;
            pending_vld <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            active_half <= active_next;
            pending     <= pending_next;
            pending_vld <= pending_vld_next;
            cfg_ready_q <= (state_next == IDLE) || !pending_vld_next;
            cfg_err_q   <= xfer && !legal;
            busy        <= is_busy(state_next);
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_MHz (clk_MHz),
        .reset_n (reset_n),
        .en      (is_busy(state)),
        .restart (core_restart),
        .half    (active_half),
        .clk_out (clk_out),
        .tick    (tick),
        .fall    (core_fall)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl with a short reset half-period.
// Expected tick and cfg_err cycles are queued at stimulus time and retired by a monitor.
module tb_clk_div_ctrl;

    localparam int CNT_W = 19;
    localparam int HALF0 = 3;

    logic clk_MHz = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic stop    = 1'b0;
    logic clk_out, tick, busy;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_bus ();

    clk_div_ctrl #(
        .CNT_W    (CNT_W),
        .DEF_HALF (HALF0),
        .MIN_HALF (1)
    ) dut (
        .clk_MHz (clk_MHz),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .cfg     (cfg_bus),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    always #10 clk_MHz = ~clk_MHz;

    int unsigned edge_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned tick_q[$];
    int unsigned err_q[$];
    int unsigned mon_exp;

    always @(posedge clk_MHz) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_MHz);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic exp_clk, input logic exp_busy);
        check({tag, "_clk_out"}, clk_out, exp_clk);
        check({tag, "_busy"}, busy, exp_busy);
    endtask

    // Scoreboard: each observed tick / cfg_err must match the next queued cycle.
    always @(negedge clk_MHz) begin
        if (tick === 1'b1) begin
            if (tick_q.size() == 0) check("tick_spurious", tick, 1'b0);
            else begin
                mon_exp = tick_q.pop_front();
                check("tick_cycle", edge_cnt, mon_exp);
            end
        end
        if (cfg_bus.cfg_err === 1'b1) begin
            if (err_q.size() == 0) check("cfg_err_spurious", cfg_bus.cfg_err, 1'b0);
            else begin
                mon_exp = err_q.pop_front();
                check("cfg_err_cycle", edge_cnt, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c, s, f, g, h;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_half  = '0;

        // Reset values
        repeat (3) next_cyc();
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg_ready", cfg_bus.cfg_ready, 1'b1);
        check("rst_cfg_err", cfg_bus.cfg_err, 1'b0);
        @(negedge clk_MHz);
        reset_n = 1'b1;
        next_cyc();
        check_outs("idle", 1'b0, 1'b0);

        // Reset half-period: rise 5 cycles after start, period 8, stop in low phase
        c = edge_cnt;
        start = 1'b1;
        tick_q.push_back(c + 5);
        tick_q.push_back(c + 13);
        for (int k = 0; k <= 18; k++) begin
            next_cyc();
            start = 1'b0;
            stop  = (k == 17);
            check_outs("def", (k < 18) ? ((k / 4) % 2 == 1) : 1'b0, k < 18);
        end

        // Configure half=1 in IDLE, then run; an illegal 0 mid-run is rejected
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 1;
        check("idle_cfg_ready", cfg_bus.cfg_ready, 1'b1);
        next_cyc();
        cfg_bus.cfg_valid = 1'b0;
        start = 1'b1;
        s = edge_cnt;
        for (int m = 0; m < 6; m++) tick_q.push_back(s + 3 + 4 * m);
        err_q.push_back(s + 7);
        for (int k = 0; k <= 25; k++) begin
            next_cyc();
            start = 1'b0;
            stop  = (k == 24);
            cfg_bus.cfg_valid = (k == 5);
            cfg_bus.cfg_half  = '0;
            check_outs("h1", (k < 25) ? ((k / 2) % 2 == 1) : 1'b0, k < 25);
            if (k == 6) check("illegal_err_pulse", cfg_bus.cfg_err, 1'b1);
            if (k == 7) check("illegal_err_done", cfg_bus.cfg_err, 1'b0);
            if (k == 6 || k == 7) check("illegal_ready", cfg_bus.cfg_ready, 1'b1);
        end

        // half=3 with start; 7 offered in high phase; stop+5 in high phase, 2 held off
        f = edge_cnt;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 3;
        start = 1'b1;
        tick_q.push_back(f + 5);
        tick_q.push_back(f + 17);
        for (int k = 0; k <= 24; k++) begin
            next_cyc();
            start = 1'b0;
            stop  = (k == 18);
            cfg_bus.cfg_valid = (k == 5) || (k >= 18 && k <= 23);
            cfg_bus.cfg_half  = (k == 5) ? 7 : (k == 18) ? 5 : 2;
            check_outs("recfg",
                       (k < 8) ? ((k / 4) % 2 == 1) : (k < 24) ? (((k - 8) / 8) % 2 == 1) : 1'b0,
                       k < 24);
            check("recfg_ready", cfg_bus.cfg_ready, !(k == 6 || k == 7 || (k >= 19 && k <= 23)));
        end

        // Pending 5 applied on the final stopping wrap; reset while high
        g = edge_cnt;
        start = 1'b1;
        tick_q.push_back(g + 7);
        for (int k = 0; k <= 7; k++) begin
            next_cyc();
            start = 1'b0;
            check_outs("h5", (k / 6) % 2 == 1, 1'b1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_clk_out", clk_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", cfg_bus.cfg_ready, 1'b1);
        next_cyc();
        next_cyc();
        check_outs("in_rst", 1'b0, 1'b0);
        reset_n = 1'b1;

        // start and stop together in IDLE: stay idle
        next_cyc();
        start = 1'b1;
        stop  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            start = 1'b0;
            stop  = 1'b0;
            check_outs("start_stop", 1'b0, 1'b0);
        end

        // Default half after reset; stop mid-high completes the phase, start ignored
        h = edge_cnt;
        start = 1'b1;
        tick_q.push_back(h + 5);
        tick_q.push_back(h + 13);
        for (int k = 0; k <= 17; k++) begin
            next_cyc();
            start = (k == 14 || k == 15);
            stop  = (k == 13);
            check_outs("post_rst", (k < 16) ? ((k / 4) % 2 == 1) : 1'b0, k < 16);
        end

        repeat (4) next_cyc();
        check("tick_q_left", tick_q.size(), 0);
        check("err_q_left", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
